// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU and the loader port.
// Latency: gnt 1 cycle after req when idle; rvalid RD_LAT+1 cycles after gnt. Backpressure: one access outstanding, other requests wait.
module mem_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int   CW      = $clog2(RD_LAT + 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last_owner, last_owner_nxt;
    logic          we_q, we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_LDR;
            we_q       <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            we_q       <= we_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        we_nxt         = we_q;
        addr_nxt       = mem_addr;
        wdata_nxt      = mem_wdata;
        cnt_nxt        = cnt;
        capture        = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    // Under contention the port that did not go last wins.
                    owner_nxt = (cpu_req && ldr_req) ? ~last_owner : ldr_req;
                    if (owner_nxt == OWN_CPU) begin
                        we_nxt    = cpu_we;
                        addr_nxt  = cpu_addr;
                        wdata_nxt = cpu_wdata;
                    end else begin
                        we_nxt    = ldr_we;
                        addr_nxt  = ldr_addr;
                        wdata_nxt = ldr_wdata;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                last_owner_nxt = owner;
                if (we_q) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            mem_en     <= (state_nxt == ACCESS);
            mem_we     <= (state_nxt == ACCESS) && we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            cpu_gnt    <= (state_nxt == ACCESS) && (owner_nxt == OWN_CPU);
            ldr_gnt    <= (state_nxt == ACCESS) && (owner_nxt == OWN_LDR);
            cpu_rvalid <= (state_nxt == RESP) && (owner == OWN_CPU);
            ldr_rvalid <= (state_nxt == RESP) && (owner == OWN_LDR);
            busy       <= (state_nxt != IDLE);
            if (capture && owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (capture && owner == OWN_LDR) ldr_rdata <= mem_rdata;
        end
    end
endmodule
